// File: rtl/bdiv_seq_2nxn.sv
// bdiv_seq_2nxn
//   Iterative restoring divider. A 2N-bit dividend A is divided by an N-bit
//   divisor B, producing a 2N-bit quotient Q and an N-bit remainder R so that
//   A == Q*B + R. One quotient bit is produced per clock.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous active-high reset, aborts any operation
//   in_valid   : request valid (A, B qualified by it)
//   in_ready   : divider idle and able to accept a request
//   A          : dividend, unsigned, 2N bits
//   B          : divisor, unsigned, N bits
//   out_valid  : result valid (Q, R, dz qualified by it)
//   out_ready  : consumer takes the result
//   Q          : quotient, 2N bits (all ones on divide by zero)
//   R          : remainder, N bits (zero on divide by zero)
//   dz         : divide-by-zero flag
module bdiv_seq_2nxn #(
  parameter int N = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] A,
  input  logic [N-1:0]   B,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] Q,
  output logic [N-1:0]   R,
  output logic           dz
);

  localparam int CW = $clog2(2*N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_next;

  logic [2*N-1:0] r_a;      // dividend, shifted left one bit per iteration
  logic [2*N-1:0] r_quo;    // quotient bits collected so far
  logic [N-1:0]   r_b;      // captured divisor
  logic [N-1:0]   r_p;      // partial remainder; always < B so N bits suffice
  logic [CW-1:0]  r_cnt;    // iterations remaining minus one

  logic [N:0]     w_t;
  logic [N-1:0]   w_diff;
  logic           w_ge;
  logic [N-1:0]   w_p_next;
  logic [2*N-1:0] w_quo_next;

  // One restoring step: bring down the next dividend bit and subtract the
  // divisor when it fits. When t >= B the true difference is < B, so the
  // low N bits of the modular subtraction are exact.
  always_comb begin
    w_t        = {r_p, r_a[2*N-1]};
    w_ge       = (w_t >= {1'b0, r_b});
    w_diff     = w_t[N-1:0] - r_b;
    w_p_next   = w_ge ? w_diff : w_t[N-1:0];
    w_quo_next = {r_quo[2*N-2:0], w_ge};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_next = (B == '0) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (r_cnt == '0) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  // Datapath and result registers. Q/R/dz are only written on the edge that
  // enters DONE (or by reset), so they stay stable throughout a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_quo <= '0;
      r_b   <= '0;
      r_p   <= '0;
      r_cnt <= '0;
      Q     <= '0;
      R     <= '0;
      dz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a   <= A;
            r_b   <= B;
            r_p   <= '0;
            r_quo <= '0;
            r_cnt <= CW'(2*N-1);
            if (B == '0) begin
              Q  <= '1;
              R  <= '0;
              dz <= 1'b1;
            end
          end
        end
        S_CALC: begin
          r_a   <= {r_a[2*N-2:0], 1'b0};
          r_p   <= w_p_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == '0) begin
            Q  <= w_quo_next;
            R  <= w_p_next;
            dz <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bdiv_seq_2nxn.sv
module tb_bdiv_seq_2nxn;
  localparam int N = 12;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] A;
  logic [N-1:0]   B;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] Q;
  logic [N-1:0]   R;
  logic           dz;

  bdiv_seq_2nxn #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Q         (Q),
    .R         (R),
    .dz        (dz)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    logic [2*N-1:0] a;
    logic [N-1:0]   b;
    int             acc;
  } req_t;

  req_t q_exp[$];
  req_t cur;
  bit   seen = 1'b0;
  bit   expect_idle = 1'b0;
  longint unsigned m_q, m_r, m_loop;

  // Sampled on the falling edge: inputs and outputs are stable and describe
  // what the next rising edge will see.
  always @(negedge clk) begin
    if (rst) begin
      q_exp.delete();
      seen        = 1'b0;
      expect_idle = 1'b0;
    end else begin
      if (expect_idle) begin
        chk("retire_in_ready", {63'd0, in_ready}, 64'd1);
        chk("retire_out_valid", {63'd0, out_valid}, 64'd0);
        expect_idle = 1'b0;
      end
      if (out_valid) begin
        if (q_exp.size() == 0) begin
          chk("spurious_out_valid", {63'd0, out_valid}, 64'd0);
        end else begin
          cur = q_exp[0];
          if (cur.b == '0) begin
            chk("dz_flag", {63'd0, dz}, 64'd1);
            chk("dz_Q", {40'd0, Q}, 64'hFFFFFF);
            chk("dz_R", {52'd0, R}, 64'd0);
          end else begin
            m_q = longint'(cur.a) / longint'(cur.b);
            m_r = longint'(cur.a) % longint'(cur.b);
            chk("Q", {40'd0, Q}, m_q);
            chk("R", {52'd0, R}, m_r);
            chk("dz_clear", {63'd0, dz}, 64'd0);
            m_loop = longint'(Q) * longint'(cur.b) + longint'(R);
            chk("QxB_plus_R", m_loop, {40'd0, cur.a});
            chk("R_lt_B", {63'd0, (R < cur.b)}, 64'd1);
          end
          chk("in_ready_busy", {63'd0, in_ready}, 64'd0);
          if (!seen) begin
            chk("latency", 64'(cyc + 1 - cur.acc), (cur.b == '0) ? 64'd1 : 64'(2*N+1));
            seen = 1'b1;
          end
          if (out_ready) begin
            void'(q_exp.pop_front());
            seen        = 1'b0;
            expect_idle = 1'b1;
          end
        end
      end
      if (in_valid && in_ready) begin
        q_exp.push_back('{a: A, b: B, acc: cyc + 1});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_op(input logic [2*N-1:0] a, input logic [N-1:0] b, input int stall,
                       output logic [2*N-1:0] q, output logic [N-1:0] r, output logic d);
    int t;
    q = '0; r = '0; d = 1'b0;
    @(posedge clk); #1;
    A = a; B = b; in_valid = 1'b1; out_ready = 1'b0;
    t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 100) begin
      chk("accept_timeout", {63'd0, in_ready}, 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 100) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 100) begin
      chk("result_timeout", {63'd0, out_valid}, 64'd1);
      return;
    end
    repeat (stall) begin
      @(posedge clk); #1;
    end
    q = Q; r = R; d = dz;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  logic [2*N-1:0] rq;
  logic [N-1:0]   rr;
  logic           rd;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_Q", {40'd0, Q}, 64'd0);
    chk("rst_R", {52'd0, R}, 64'd0);
    chk("rst_dz", {63'd0, dz}, 64'd0);
    rst = 1'b0;

    // T1
    do_op(24'h000064, 12'h007, 0, rq, rr, rd);
    chk("T1_Q", {40'd0, rq}, 64'h00000E);
    chk("T1_R", {52'd0, rr}, 64'h002);
    chk("T1_dz", {63'd0, rd}, 64'd0);
    // T2
    do_op(24'hFFFFFF, 12'h001, 1, rq, rr, rd);
    chk("T2a_Q", {40'd0, rq}, 64'hFFFFFF);
    chk("T2a_R", {52'd0, rr}, 64'h0);
    do_op(24'h000005, 12'hFFF, 0, rq, rr, rd);
    chk("T2b_Q", {40'd0, rq}, 64'h0);
    chk("T2b_R", {52'd0, rr}, 64'h5);
    // T3
    do_op(24'h123456, 12'h000, 0, rq, rr, rd);
    chk("T3_dz", {63'd0, rd}, 64'd1);
    chk("T3_Q", {40'd0, rq}, 64'hFFFFFF);
    chk("T3_R", {52'd0, rr}, 64'h0);
    // T4: ten-cycle stall, stability checked every cycle by the scoreboard
    do_op(24'hABCDEF, 12'h3A5, 10, rq, rr, rd);
    // T5: abort in the middle of CALC
    @(posedge clk); #1;
    A = 24'h765432; B = 12'h0F1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("T5_out_valid", {63'd0, out_valid}, 64'd0);
    chk("T5_in_ready", {63'd0, in_ready}, 64'd1);
    chk("T5_Q", {40'd0, Q}, 64'd0);
    chk("T5_R", {52'd0, R}, 64'd0);
    chk("T5_dz", {63'd0, dz}, 64'd0);
    do_op(24'h00ABCD, 12'h123, 0, rq, rr, rd);
    chk("T5_new_Q", {40'd0, rq}, 64'h000097);
    chk("T5_new_R", {52'd0, rr}, 64'h028);
    // T6: random operands with random result stalls
    for (int i = 0; i < 300; i++) begin
      do_op(24'($urandom_range(0, 24'hFFFFFF)), 12'($urandom_range(1, 12'hFFF)),
            int'($urandom_range(0, 3)), rq, rr, rd);
    end
    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 64'(q_exp.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
